// File: rtl/alu_cc_pipe.sv
// One-stage pipelined ALU with the Y86 condition-code register and branch/cmov condition evaluation.
// Latency 1 cycle; a held, unconsumed result drops in_ready, so no bundle is accepted and CC is untouched.
module alu_cc_pipe #(
    parameter int W   = 64,
    parameter int SHW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         set_cc,
    input  logic [3:0]   cond_fn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         res_zf,
    output logic         res_sf,
    output logic         res_of,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of,
    output logic         cond_true
);
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } flags_t;

    localparam flags_t FLAGS_RST = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SAR = 3'd7;

    logic           accept;
    logic [SHW-1:0] shamt;
    logic [W-1:0]   alu_r;
    flags_t         alu_f;
    logic           sign_ne;

    logic           out_valid_d, out_valid_q;
    logic [W-1:0]   result_d, result_q;
    flags_t         res_f_d, res_f_q;
    flags_t         cc_d, cc_q;

    always_comb begin
        shamt    = b[SHW-1:0];
        alu_r    = '0;
        alu_f.of = 1'b0;
        case (op)
            OP_ADD: begin
                alu_r    = a + b;
                alu_f.of = (a[W-1] == b[W-1]) && (alu_r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                alu_r    = a - b;
                alu_f.of = (a[W-1] != b[W-1]) && (alu_r[W-1] != a[W-1]);
            end
            OP_AND:  alu_r = a & b;
            OP_XOR:  alu_r = a ^ b;
            OP_OR:   alu_r = a | b;
            OP_SHL:  alu_r = a << shamt;
            OP_SHR:  alu_r = a >> shamt;
            OP_SAR:  alu_r = $signed(a) >>> shamt;
            default: alu_r = '0;
        endcase
        alu_f.zf = (alu_r == '0);
        alu_f.sf = alu_r[W-1];
    end

    // Accept and drain may coincide: the new result overwrites the one leaving.
    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        res_f_d     = res_f_q;
        cc_d        = cc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = alu_r;
            res_f_d     = alu_f;
            if (set_cc) begin
                cc_d = alu_f;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            res_f_q     <= FLAGS_RST;
            cc_q        <= FLAGS_RST;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            res_f_q     <= res_f_d;
            cc_q        <= cc_d;
        end
    end

    // Conditions read the CC value held before the current accept edge.
    always_comb begin
        sign_ne = cc_q.sf ^ cc_q.of;
        case (cond_fn)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = sign_ne || cc_q.zf;
            4'd2:    cond_true = sign_ne;
            4'd3:    cond_true = cc_q.zf;
            4'd4:    cond_true = !cc_q.zf;
            4'd5:    cond_true = !sign_ne;
            4'd6:    cond_true = !sign_ne && !cc_q.zf;
            default: cond_true = 1'b0;
        endcase
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign res_zf    = res_f_q.zf;
    assign res_sf    = res_f_q.sf;
    assign res_of    = res_f_q.of;
    assign cc_zf     = cc_q.zf;
    assign cc_sf     = cc_q.sf;
    assign cc_of     = cc_q.of;

endmodule

// File: tb/tb_alu_cc_pipe.sv
// Bench for alu_cc_pipe: 64-bit and 8-bit instances driven in lockstep, checked against an arithmetic reference.
module tb_alu_cc_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        set_cc;
    logic [3:0]  cond_fn;
    logic        out_ready;

    logic        ir64, ov64, rz64, rs64, ro64, cz64, cs64, co64, ct64;
    logic [63:0] r64;
    logic        ir8, ov8, rz8, rs8, ro8, cz8, cs8, co8, ct8;
    logic [7:0]  r8;

    int errors = 0;
    int checks = 0;

    // Reference state per instance: index 0 is W=64, index 1 is W=8.
    logic        mv   [2];
    logic [63:0] mres [2];
    logic [2:0]  mf   [2];
    logic [2:0]  mcc  [2];

    logic        got_ir  [2];
    logic        got_ov  [2];
    logic        got_ct  [2];
    logic [63:0] got_res [2];
    logic [2:0]  got_f   [2];
    logic [2:0]  got_cc  [2];

    assign got_ir[0]  = ir64;
    assign got_ir[1]  = ir8;
    assign got_ov[0]  = ov64;
    assign got_ov[1]  = ov8;
    assign got_ct[0]  = ct64;
    assign got_ct[1]  = ct8;
    assign got_res[0] = r64;
    assign got_res[1] = {56'd0, r8};
    assign got_f[0]   = {rz64, rs64, ro64};
    assign got_f[1]   = {rz8, rs8, ro8};
    assign got_cc[0]  = {cz64, cs64, co64};
    assign got_cc[1]  = {cz8, cs8, co8};

    alu_cc_pipe #(.W(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64), .op(op),
        .a(a), .b(b), .set_cc(set_cc), .cond_fn(cond_fn), .out_valid(ov64),
        .out_ready(out_ready), .result(r64), .res_zf(rz64), .res_sf(rs64),
        .res_of(ro64), .cc_zf(cz64), .cc_sf(cs64), .cc_of(co64), .cond_true(ct64)
    );

    alu_cc_pipe #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .op(op),
        .a(a[7:0]), .b(b[7:0]), .set_cc(set_cc), .cond_fn(cond_fn), .out_valid(ov8),
        .out_ready(out_ready), .result(r8), .res_zf(rz8), .res_sf(rs8),
        .res_of(ro8), .cc_zf(cz8), .cc_sf(cs8), .cc_of(co8), .cond_true(ct8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Signed-integer reference: operands are read as w-bit two's complement numbers,
    // OF means the exact signed result does not fit in w bits.
    function automatic void alu_ref(input int w, input logic [2:0] fop, input logic [63:0] a_i,
                                    input logic [63:0] b_i, output logic [63:0] r, output logic [2:0] f);
        logic [63:0]        mask, av, bv;
        logic signed [65:0] sa, sb, full, lim;
        int                 sh;
        logic               of;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        av   = a_i & mask;
        bv   = b_i & mask;
        sa   = $signed({2'b00, av});
        sb   = $signed({2'b00, bv});
        if (av[w-1]) sa = sa - (66'sd1 <<< w);
        if (bv[w-1]) sb = sb - (66'sd1 <<< w);
        lim  = 66'sd1 <<< (w - 1);
        sh   = int'(bv % 64'(w));
        of   = 1'b0;
        full = '0;
        case (fop)
            3'd0: begin full = sa + sb; of = (full >= lim) || (full < -lim); end
            3'd1: begin full = sa - sb; of = (full >= lim) || (full < -lim); end
            3'd2: full = $signed({2'b00, av & bv});
            3'd3: full = $signed({2'b00, av ^ bv});
            3'd4: full = $signed({2'b00, av | bv});
            3'd5: full = $signed({2'b00, av << sh});
            3'd6: full = $signed({2'b00, av >> sh});
            default: full = sa >>> sh;
        endcase
        r = full[63:0] & mask;
        f = {r == 64'd0, r[w-1], of};
    endfunction

    function automatic logic cond_ref(input logic [3:0] fn, input logic [2:0] cc);
        logic z, lt;
        z  = cc[2];
        lt = cc[1] ^ cc[0];
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return lt || z;
            4'd2:    return lt;
            4'd3:    return z;
            4'd4:    return !z;
            4'd5:    return !lt;
            4'd6:    return !lt && !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mv[k]   = 1'b0;
            mres[k] = '0;
            mf[k]   = 3'b100;
            mcc[k]  = 3'b100;
        end
    endtask

    // Advance the reference over the coming rising edge, then wait to the next falling edge.
    task automatic step();
        logic [63:0] r;
        logic [2:0]  f;
        for (int k = 0; k < 2; k++) begin
            if (in_valid && (!mv[k] || out_ready)) begin
                alu_ref((k == 0) ? 64 : 8, op, a, b, r, f);
                mv[k]   = 1'b1;
                mres[k] = r;
                mf[k]   = f;
                if (set_cc) mcc[k] = f;
            end else if (mv[k] && out_ready) begin
                mv[k] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        checks++; if (ov64 !== 1'b0) begin errors++; $display("FAIL reset_ov64 got=%b exp=0", ov64); end
        checks++; if (r64 !== 64'd0) begin errors++; $display("FAIL reset_res64 got=%h exp=0", r64); end
        checks++; if ({rz64, rs64, ro64} !== 3'b100) begin errors++; $display("FAIL reset_resf64 got=%b exp=100", {rz64, rs64, ro64}); end
        checks++; if ({cz64, cs64, co64} !== 3'b100) begin errors++; $display("FAIL reset_cc64 got=%b exp=100", {cz64, cs64, co64}); end
        checks++; if (ir64 !== 1'b1) begin errors++; $display("FAIL reset_ir64 got=%b exp=1", ir64); end
        checks++; if ({ov8, r8, cz8, cs8, co8} !== {1'b0, 8'h00, 3'b100}) begin errors++; $display("FAIL reset_dut8 got=%b/%h/%b exp=0/00/100", ov8, r8, {cz8, cs8, co8}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_flags();
        in_valid = 1'b1; op = 3'd0; a = 64'd2000; b = 64'd60; set_cc = 1'b1; out_ready = 1'b1; cond_fn = 4'd0;
        step();
        checks++; if (r64 !== 64'd2060 || ov64 !== 1'b1) begin errors++; $display("FAIL add_res got=%0d/%b exp=2060/1", r64, ov64); end
        checks++; if ({rz64, rs64, ro64, cz64, cs64, co64} !== 6'b000000) begin errors++; $display("FAIL add_flags got=%b exp=000000", {rz64, rs64, ro64, cz64, cs64, co64}); end
        in_valid = 1'b0; cond_fn = 4'd6; #1;
        checks++; if (ct64 !== 1'b1) begin errors++; $display("FAIL cond_g got=%b exp=1", ct64); end
        step();
        in_valid = 1'b1; a = 64'd3; b = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        checks++; if (r64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL add_neg got=%h exp=ffffffffffffffff", r64); end
        checks++; if ({rz64, rs64, ro64} !== 3'b010) begin errors++; $display("FAIL add_neg_flags got=%b exp=010", {rz64, rs64, ro64}); end
        in_valid = 1'b0; cond_fn = 4'd2; #1;
        checks++; if (ct64 !== 1'b1) begin errors++; $display("FAIL cond_l got=%b exp=1", ct64); end
        cond_fn = 4'd5; #1;
        checks++; if (ct64 !== 1'b0) begin errors++; $display("FAIL cond_ge got=%b exp=0", ct64); end
        step();
        in_valid = 1'b1; a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1;
        step();
        checks++; if (r64 !== 64'h8000_0000_0000_0000 || {rs64, ro64} !== 2'b11) begin errors++; $display("FAIL add_ovf got=%h/%b exp=8000000000000000/11", r64, {rs64, ro64}); end
        op = 3'd1; a = 64'hCCCC_CCCC_CCCC_CCCC; b = 64'hCCCC_CCCC_CCCC_CCCC;
        step();
        checks++; if (r64 !== 64'd0 || {rz64, ro64} !== 2'b10) begin errors++; $display("FAIL sub_zero got=%h/%b exp=0/10", r64, {rz64, ro64}); end
        in_valid = 1'b0; cond_fn = 4'd3; #1;
        checks++; if (ct64 !== 1'b1) begin errors++; $display("FAIL cond_e got=%b exp=1", ct64); end
        step();
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; op = 3'd1; a = 64'd1000; b = 64'd500; set_cc = 1'b1; out_ready = 1'b0;
        step();
        checks++; if (r64 !== 64'd500 || ov64 !== 1'b1) begin errors++; $display("FAIL bp_first got=%0d/%b exp=500/1", r64, ov64); end
        a = 64'd10; b = 64'd70;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ir64 !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, ir64); end
            step();
            checks++; if (r64 !== 64'd500 || ov64 !== 1'b1) begin errors++; $display("FAIL bp_hold cyc=%0d got=%0d/%b exp=500/1", i, r64, ov64); end
            checks++; if ({cz64, cs64, co64} !== 3'b000) begin errors++; $display("FAIL bp_cc cyc=%0d got=%b exp=000", i, {cz64, cs64, co64}); end
        end
        out_ready = 1'b1; #1;
        checks++; if (ir64 !== 1'b1) begin errors++; $display("FAIL bp_release_ir got=%b exp=1", ir64); end
        step();
        checks++; if (r64 !== 64'hFFFF_FFFF_FFFF_FFC4 || rs64 !== 1'b1 || ov64 !== 1'b1) begin errors++; $display("FAIL bp_second got=%h/%b/%b exp=ffffffffffffffc4/1/1", r64, rs64, ov64); end
        checks++; if ({cz64, cs64, co64} !== 3'b010) begin errors++; $display("FAIL bp_cc_after got=%b exp=010", {cz64, cs64, co64}); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_w8_ops();
        logic [2:0] t_op [4];
        logic [7:0] t_a  [4];
        logic [7:0] t_b  [4];
        logic [7:0] t_r  [4];
        t_op = '{3'd7, 3'd6, 3'd5, 3'd2};
        t_a  = '{8'h80, 8'h80, 8'h81, 8'hCC};
        t_b  = '{8'h03, 8'h03, 8'h01, 8'hAA};
        t_r  = '{8'hF0, 8'h10, 8'h02, 8'h88};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; op = t_op[i]; a = {56'd0, t_a[i]}; b = {56'd0, t_b[i]}; set_cc = (i != 3);
            step();
            checks++; if (r8 !== t_r[i] || ov8 !== 1'b1) begin errors++; $display("FAIL w8_op%0d got=%h/%b exp=%h/1", t_op[i], r8, ov8, t_r[i]); end
        end
        checks++; if ({rz8, rs8, ro8} !== 3'b010) begin errors++; $display("FAIL w8_and_flags got=%b exp=010", {rz8, rs8, ro8}); end
        checks++; if ({cz8, cs8, co8} !== 3'b000) begin errors++; $display("FAIL w8_cc_hold got=%b exp=000", {cz8, cs8, co8}); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [63:0] corner [6];
        corner = '{64'd0, 64'd1, '1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_807F};
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            op        = 3'($urandom_range(0, 7));
            set_cc    = 1'($urandom_range(0, 1));
            cond_fn   = 4'($urandom_range(0, 15));
            a         = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : {$urandom, $urandom};
            b         = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) b = b & 64'h3F;
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++; if (got_ir[k] !== (!mv[k] || out_ready)) begin errors++; $display("FAIL rnd_in_ready i=%0d k=%0d got=%b exp=%b", i, k, got_ir[k], !mv[k] || out_ready); end
                checks++; if (got_ct[k] !== cond_ref(cond_fn, mcc[k])) begin errors++; $display("FAIL rnd_cond i=%0d k=%0d fn=%0d got=%b exp=%b", i, k, cond_fn, got_ct[k], cond_ref(cond_fn, mcc[k])); end
            end
            step();
            for (int k = 0; k < 2; k++) begin
                checks++; if (got_ov[k] !== mv[k]) begin errors++; $display("FAIL rnd_out_valid i=%0d k=%0d got=%b exp=%b", i, k, got_ov[k], mv[k]); end
                checks++; if (got_res[k] !== mres[k]) begin errors++; $display("FAIL rnd_result i=%0d k=%0d got=%h exp=%h", i, k, got_res[k], mres[k]); end
                checks++; if (got_f[k] !== mf[k]) begin errors++; $display("FAIL rnd_res_flags i=%0d k=%0d got=%b exp=%b", i, k, got_f[k], mf[k]); end
                checks++; if (got_cc[k] !== mcc[k]) begin errors++; $display("FAIL rnd_cc i=%0d k=%0d got=%b exp=%b", i, k, got_cc[k], mcc[k]); end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; op = 3'd0; a = 64'd5; b = 64'd5; set_cc = 1'b1; out_ready = 1'b0; cond_fn = 4'd3;
        step();
        checks++; if (ov64 !== 1'b1 || r64 !== 64'd10 || cz64 !== 1'b0) begin errors++; $display("FAIL ar_pre got=%b/%0d/%b exp=1/10/0", ov64, r64, cz64); end
        a = 64'd1; b = 64'd2;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (ov64 !== 1'b0 || ov8 !== 1'b0) begin errors++; $display("FAIL ar_out_valid got=%b/%b exp=0/0", ov64, ov8); end
        checks++; if ({cz64, cs64, co64} !== 3'b100 || {cz8, cs8, co8} !== 3'b100) begin errors++; $display("FAIL ar_cc got=%b/%b exp=100/100", {cz64, cs64, co64}, {cz8, cs8, co8}); end
        checks++; if (r64 !== 64'd0 || {rz64, rs64, ro64} !== 3'b100) begin errors++; $display("FAIL ar_result got=%h/%b exp=0/100", r64, {rz64, rs64, ro64}); end
        checks++; if (ct64 !== 1'b1) begin errors++; $display("FAIL ar_cond_e got=%b exp=1", ct64); end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++; if (ov64 !== 1'b1 || r64 !== 64'd3 || r8 !== 8'd3) begin errors++; $display("FAIL ar_held_accept got=%b/%0d/%0d exp=1/3/3", ov64, r64, r8); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; set_cc = 1'b0; cond_fn = '0; out_ready = 1'b1;
        test_reset();
        test_add_flags();
        test_backpressure();
        test_w8_ops();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
